cascaded_alu_arbiter: RTL and testbench

CASCADED_ALU_ARBITER -- requirements
Module: cascaded_alu_arbiter

---
 rtl/cascaded_alu_pkg.sv | 23 ++
 rtl/cascaded_alu_arbiter_rr.sv | 35 +++
 rtl/cascaded_alu_arbiter.sv | 136 +++++++++++++
 tb/tb_cascaded_alu_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cascaded_alu_pkg.sv
// Shared types and constants for the cascaded ALU arbiter.
package cascaded_alu_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_RESULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

endpackage

// File: rtl/cascaded_alu_arbiter_rr.sv
// Two-way round-robin arbiter: grants the requester that did not win last,
// remembering the winner only when the grant is actually taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant,
  output logic       ptr
);

  logic r_ptr;

  // Pick the grant index from the pending requests and the last winner.
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~r_ptr;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

  // Last-grant pointer starts at 1 so requester 0 wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b1;
    end else if (accept) begin
      r_ptr <= grant;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/cascaded_alu_arbiter.sv
// Two-requester front end for a multi-cycle ALU: arbitrates, issues one
// operation at a time, waits for completion or timeout, and holds the
// response until the consumer takes it.
module cascaded_alu_arbiter
  import cascaded_alu_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int TIMEOUT      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [DATA_WIDTH-1:0]   req0_A,
  input  logic [DATA_WIDTH-1:0]   req0_B,
  input  logic [2:0]              req0_op,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [DATA_WIDTH-1:0]   req1_A,
  input  logic [DATA_WIDTH-1:0]   req1_B,
  input  logic [2:0]              req1_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [RESULT_WIDTH-1:0] rsp_result,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   alu_A,
  output logic [DATA_WIDTH-1:0]   alu_B,
  output logic [2:0]              alu_op_sel,
  output logic                    alu_start_op,
  input  logic                    alu_end_op,
  input  logic [RESULT_WIDTH-1:0] alu_result
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [2:0]              r_op;
  logic                    r_start;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_rsp_valid;
  logic                    r_rsp_err;
  logic [RESULT_WIDTH-1:0] r_rsp_result;

  logic [1:0] w_req;
  logic       w_grant;
  logic       w_ptr;
  logic       w_accept;

  assign w_req    = {req1_valid, req0_valid};
  // A request held during reset is never taken, so ready stays low there.
  assign w_accept = (r_state == ST_IDLE) && !rst && w_req[w_grant];

  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept &&  w_grant;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (w_req),
    .accept (w_accept),
    .grant  (w_grant),
    .ptr    (w_ptr)
  );

  // The pointer holds the accepted requester until the next acceptance,
  // which cannot happen before RESP is left, so it doubles as the response id.
  assign rsp_id       = (r_state == ST_RESP) && w_ptr;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_err      = r_rsp_err;
  assign rsp_result   = r_rsp_result;
  assign alu_A        = r_a;
  assign alu_B        = r_b;
  assign alu_op_sel   = r_op;
  assign alu_start_op = r_start;

  // Control FSM with registered ALU-side and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_start      <= 1'b0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant ? req1_A  : req0_A;
            r_b     <= w_grant ? req1_B  : req0_B;
            r_op    <= w_grant ? req1_op : req0_op;
            r_start <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (alu_end_op) begin
            r_rsp_result <= alu_result;
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_cnt        <= r_cnt + 1'b1;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b1;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cascaded_alu_arbiter.sv
// Directed bench for cascaded_alu_arbiter with a behavioural cascaded ALU
// (3-cycle multiply, 1-cycle for the other ops) and a response scoreboard.
module tb_cascaded_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_A, req0_B, req1_A, req1_B;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [15:0] alu_A, alu_B;
  logic [2:0]  alu_op_sel;
  logic        alu_start_op, alu_end_op;
  logic [31:0] alu_result;

  cascaded_alu_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_A       (req0_A),
    .req0_B       (req0_B),
    .req0_op      (req0_op),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_A       (req1_A),
    .req1_B       (req1_B),
    .req1_op      (req1_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_err      (rsp_err),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_op_sel   (alu_op_sel),
    .alu_start_op (alu_start_op),
    .alu_end_op   (alu_end_op),
    .alu_result   (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural cascaded ALU
  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return 32'(a) * 32'(b);
      3'd1:    return 32'(a) + 32'(b);
      3'd2:    return 32'(a) - 32'(b);
      3'd3:    return {16'h0, a & b};
      3'd4:    return {16'h0, a | b};
      3'd5:    return {16'h0, a ^ b};
      3'd6:    return 32'(a) << b[3:0];
      default: return {16'h0, ~a};
    endcase
  endfunction

  logic [2:0]  m_cnt;
  logic [31:0] m_res;
  logic        alu_stuck, alu_inject;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 3'd0;
      m_res <= 32'd0;
    end else if (alu_start_op) begin
      m_cnt <= (alu_op_sel == 3'b000) ? 3'd3 : 3'd1;
      m_res <= alu_fn(alu_op_sel, alu_A, alu_B);
    end else if (m_cnt != 3'd0) begin
      m_cnt <= m_cnt - 3'd1;
    end
  end

  assign alu_end_op = ((m_cnt == 3'd1) && !alu_stuck) || alu_inject;
  assign alu_result = m_res;

  // Scoreboard and checking
  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_result", rsp_result, mon_e.res);
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  task automatic set_req(input int id, input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id == 0) begin
      req0_valid = v; req0_op = op; req0_A = a; req0_B = b;
    end else begin
      req1_valid = v; req1_op = op; req1_A = a; req1_B = b;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_one(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] res, input logic err, input int lat, input string tag);
    int   n;
    int   cyc;
    int   starts;
    exp_t e;
    e.id = id[0]; e.res = res; e.err = err;
    exp_q.push_back(e);
    @(posedge clk); #1;
    set_req(id, 1'b1, op, a, b);
    n = 0;
    @(negedge clk);
    while (((id == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_ready"}, 32'((id == 0) ? req0_ready : req1_ready), 32'd1);
    @(posedge clk); #1;
    set_req(id, 1'b0, op, a, b);
    cyc = 0;
    starts = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (alu_start_op) starts++;
      if (cyc == 1) begin
        chk({tag, "_alu_A"}, 32'(alu_A), 32'(a));
        chk({tag, "_alu_B"}, 32'(alu_B), 32'(b));
        chk({tag, "_alu_op"}, 32'(alu_op_sel), 32'(op));
      end
      if (cyc == 2) chk({tag, "_alu_A_stable"}, 32'(alu_A), 32'(a));
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_start_cycles"}, 32'(starts), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  // Directed sequence
  logic [15:0] a0[3], b0[3], a1[3], b1[3];
  int          c0, c1, g, held, cycles, seen;
  logic        hold_armed, r0, r1, s_id, s_err;
  logic [31:0] s_res;
  exp_t        e;

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    alu_stuck = 1'b0;
    alu_inject = 1'b0;
    set_req(0, 1'b1, 3'd0, 16'h0, 16'h0);
    set_req(1, 1'b1, 3'd0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_start", 32'(alu_start_op), 32'd0);
    chk("rst_alu_A", 32'(alu_A), 32'd0);
    chk("rst_alu_B", 32'(alu_B), 32'd0);
    chk("rst_alu_op", 32'(alu_op_sel), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;

    run_one(0, 3'b000, 16'd3, 16'd5, 32'h0000000F, 1'b0, 5, "mul");
    run_one(1, 3'b001, 16'h0001, 16'h0002, 32'h00000003, 1'b0, 3, "add");
    run_one(0, 3'b100, 16'h00F0, 16'h000F, 32'h000000FF, 1'b0, 3, "or");

    // Round robin with both requesters busy from reset
    do_reset();
    for (int j = 0; j < 3; j++) begin
      a0[j] = 16'h0100 + 16'(j); b0[j] = 16'(j + 1);
      a1[j] = 16'h0A50 + 16'(j); b1[j] = 16'h00F0 + 16'(j);
    end
    for (int j = 0; j < 3; j++) begin
      e.id = 1'b0; e.res = 32'(a0[j]) + 32'(b0[j]); e.err = 1'b0; exp_q.push_back(e);
      e.id = 1'b1; e.res = {16'h0, a1[j] ^ b1[j]};  e.err = 1'b0; exp_q.push_back(e);
    end
    set_req(0, 1'b1, 3'b001, a0[0], b0[0]);
    set_req(1, 1'b1, 3'b101, a1[0], b1[0]);
    c0 = 0; c1 = 0; g = 0; held = 0; cycles = 0; hold_armed = 1'b0;
    while ((c0 < 3 || c1 < 3 || exp_q.size() != 0) && cycles < 300) begin
      @(negedge clk);
      cycles++;
      r0 = req0_ready;
      r1 = req1_ready;
      if (r0 || r1) begin
        chk("rr_onehot", 32'(r0 && r1), 32'd0);
        chk("rr_grant", 32'(r1), 32'(g % 2));
        g++;
      end
      if (hold_armed && rsp_valid && !rsp_ready) begin
        if (held == 0) begin
          s_id = rsp_id; s_res = rsp_result; s_err = rsp_err;
        end else begin
          chk("hold_id", 32'(rsp_id), 32'(s_id));
          chk("hold_result", rsp_result, s_res);
          chk("hold_err", 32'(rsp_err), 32'(s_err));
        end
        chk("hold_ready0", 32'(req0_ready), 32'd0);
        chk("hold_ready1", 32'(req1_ready), 32'd0);
        held++;
      end
      @(posedge clk); #1;
      if (r0) begin
        c0++;
        if (c0 < 3) set_req(0, 1'b1, 3'b001, a0[c0], b0[c0]);
        else req0_valid = 1'b0;
      end
      if (r1) begin
        c1++;
        if (c1 < 3) set_req(1, 1'b1, 3'b101, a1[c1], b1[c1]);
        else req1_valid = 1'b0;
      end
      if (g == 2 && !hold_armed) begin
        hold_armed = 1'b1;
        rsp_ready = 1'b0;
      end
      if (held == 4) rsp_ready = 1'b1;
    end
    chk("rr_accepted", 32'(c0 + c1), 32'd6);
    chk("rr_held_cycles", 32'(held), 32'd4);
    rsp_ready = 1'b1;

    // Timeout with a silent ALU, then a stray completion while idle
    alu_stuck = 1'b1;
    run_one(0, 3'b010, 16'd9, 16'd4, 32'h0, 1'b1, 10, "tmo");
    @(posedge clk); #1;
    alu_inject = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    alu_inject = 1'b0;
    @(negedge clk);
    chk("late_end_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("late_end_start", 32'(alu_start_op), 32'd0);
    run_one(1, 3'b011, 16'h1234, 16'h00FF, 32'h0, 1'b1, 10, "tmo2");
    alu_stuck = 1'b0;

    // Reset in the middle of a multiply
    @(posedge clk); #1;
    set_req(0, 1'b1, 3'b000, 16'd7, 16'd6);
    seen = 0;
    @(negedge clk);
    while (req0_ready !== 1'b1 && seen < 20) begin
      seen++;
      @(negedge clk);
    end
    chk("abort_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_err", 32'(rsp_err), 32'd0);
    chk("abort_rsp_id", 32'(rsp_id), 32'd0);
    chk("abort_rsp_result", rsp_result, 32'd0);
    chk("abort_start", 32'(alu_start_op), 32'd0);
    chk("abort_alu_A", 32'(alu_A), 32'd0);
    chk("abort_alu_B", 32'(alu_B), 32'd0);
    chk("abort_alu_op", 32'(alu_op_sel), 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);

    e.id = 1'b0; e.res = 32'd4; e.err = 1'b0; exp_q.push_back(e);
    @(posedge clk); #1;
    set_req(0, 1'b1, 3'b001, 16'd2, 16'd2);
    set_req(1, 1'b1, 3'b001, 16'd9, 16'd9);
    @(negedge clk);
    chk("post_rst_ready0", 32'(req0_ready), 32'd1);
    chk("post_rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
